// File: rtl/pat_pkg.sv
// Shared types and constants for the pattern stream scheduler.
// State encoding, source-select modes and the default pattern word width.
package pat_pkg;

  localparam int DATA_W_DEF = 256;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_GAP    = 3'd2,
    S_ZERO   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] MODE_SRC0 = 2'd0;
  localparam logic [1:0] MODE_SRC1 = 2'd1;
  localparam logic [1:0] MODE_ALT  = 2'd2;

  // Reserved mode 3 falls through to src0.
  function automatic logic use_src1(input logic [1:0] mode, input logic odd);
    return (mode == MODE_SRC1) || ((mode == MODE_ALT) && odd);
  endfunction

endpackage

// File: rtl/pat_src_mux.sv
// Combinational 2:1 selection of the active FWFT source and steering of its pop.
// Zero latency; a pop is raised only when the caller's request and the selected valid coincide.
module pat_src_mux
  import pat_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        mode,
  input  logic              odd,
  input  logic              req,
  input  logic [DATA_W-1:0] src0_dout,
  input  logic              src0_valid,
  input  logic [DATA_W-1:0] src1_dout,
  input  logic              src1_valid,
  output logic              xfer,
  output logic [DATA_W-1:0] sel_dout,
  output logic              src0_rd_en,
  output logic              src1_rd_en
);

  logic sel1;
  logic sel_valid;

  assign sel1       = use_src1(mode, odd);
  assign sel_valid  = sel1 ? src1_valid : src0_valid;
  assign sel_dout   = sel1 ? src1_dout : src0_dout;
  assign xfer       = req & sel_valid;
  assign src0_rd_en = xfer & ~sel1;
  assign src1_rd_en = xfer & sel1;

endmodule

// File: rtl/pat_stream_scheduler.sv
// Streams one exposure (num_pat subframes of num_streams words, plus an optional zero subframe)
// from two FWFT sources into the output FIFO; pop-to-write latency 1 cycle, stalls while out_full.
module pat_stream_scheduler
  import pat_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAP_CYC    = 1,
  parameter int ZERO_FRAME = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [31:0]       num_pat,
  input  logic [15:0]       num_streams,
  input  logic [DATA_W-1:0] src0_dout,
  input  logic              src0_valid,
  output logic              src0_rd_en,
  input  logic [DATA_W-1:0] src1_dout,
  input  logic              src1_valid,
  output logic              src1_rd_en,
  input  logic              out_full,
  output logic              out_wr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       subframe_idx
);

  localparam logic [15:0] GAP_LAST = (GAP_CYC > 1) ? 16'(GAP_CYC - 1) : 16'd0;

  state_t            state, state_nxt;
  logic [31:0]       cfg_np;
  logic [15:0]       cfg_ns;
  logic [1:0]        cfg_mode;
  logic [15:0]       cnt, cnt_nxt;
  logic [15:0]       gap_cnt, gap_nxt;
  logic [31:0]       idx_nxt, idx_inc;
  logic              wr_nxt, done_nxt, load_cfg;
  logic [DATA_W-1:0] data_nxt, sel_dout;
  logic              req, xfer, last_word, room;

  assign room      = cnt < cfg_ns;
  assign last_word = (cnt == cfg_ns - 16'd1);
  assign idx_inc   = subframe_idx + 32'd1;
  // Abort and a full output both veto the pop in the same cycle.
  assign req       = (state == S_STREAM) & ~abort & ~out_full & room;
  assign busy      = (state != S_IDLE);
  assign load_cfg  = (state == S_IDLE) & start & ~abort;

  pat_src_mux #(.DATA_W(DATA_W)) u_mux (
    .mode       (cfg_mode),
    .odd        (subframe_idx[0]),
    .req        (req),
    .src0_dout  (src0_dout),
    .src0_valid (src0_valid),
    .src1_dout  (src1_dout),
    .src1_valid (src1_valid),
    .xfer       (xfer),
    .sel_dout   (sel_dout),
    .src0_rd_en (src0_rd_en),
    .src1_rd_en (src1_rd_en)
  );

  always_comb begin
    state_nxt = state;
    wr_nxt    = 1'b0;
    data_nxt  = out_data;
    cnt_nxt   = cnt;
    gap_nxt   = gap_cnt;
    idx_nxt   = subframe_idx;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt_nxt   = '0;
            gap_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = (num_pat == 32'd0 || num_streams == 16'd0) ? S_DONE : S_STREAM;
          end
        end
        S_STREAM: begin
          gap_nxt = '0;
          if (xfer) begin
            wr_nxt   = 1'b1;
            data_nxt = sel_dout;
            cnt_nxt  = cnt + 16'd1;
            if (last_word) state_nxt = S_GAP;
          end else if (!room) begin
            state_nxt = S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            gap_nxt = '0;
            cnt_nxt = '0;
            idx_nxt = idx_inc;
            if (idx_inc == cfg_np) state_nxt = (ZERO_FRAME != 0) ? S_ZERO : S_DONE;
            else                   state_nxt = S_STREAM;
          end else begin
            gap_nxt = gap_cnt + 16'd1;
          end
        end
        S_ZERO: begin
          if (!out_full && room) begin
            wr_nxt   = 1'b1;
            data_nxt = '0;
            cnt_nxt  = cnt + 16'd1;
            if (last_word) state_nxt = S_DONE;
          end else if (!room) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      out_wr       <= 1'b0;
      out_data     <= '0;
      done         <= 1'b0;
      subframe_idx <= '0;
      cnt          <= '0;
      gap_cnt      <= '0;
      cfg_np       <= '0;
      cfg_ns       <= '0;
      cfg_mode     <= MODE_SRC0;
    end else begin
      state        <= state_nxt;
      out_wr       <= wr_nxt;
      out_data     <= data_nxt;
      done         <= done_nxt;
      subframe_idx <= idx_nxt;
      cnt          <= cnt_nxt;
      gap_cnt      <= gap_nxt;
      if (load_cfg) begin
        cfg_np   <= num_pat;
        cfg_ns   <= num_streams;
        cfg_mode <= mode;
      end
    end
  end

endmodule
